// File: rtl/scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : scan_sequencer
//  Description : Film-scanner scan sequencer. Wakes the stepper driver, homes
//                the carriage, then repeats step / settle / CCD-capture for a
//                programmed number of lines. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_sequencer #(
    parameter int unsigned STEP_HALF  = 5000,
    parameter int unsigned SETTLE_CYC = 100000,
    parameter int unsigned HOME_MAX   = 20000
) (
    input  logic        clk_100M,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] num_lines,
    input  logic [7:0]  steps_per_line,
    input  logic        dir_fwd,
    input  logic        mtr_nhome,
    input  logic        mtr_nflt,
    input  logic        line_done,
    output logic        mtr_nen,
    output logic        mtr_step,
    output logic        mtr_dir,
    output logic        mtr_nrst,
    output logic        mtr_slp,
    output logic        ccd_trig,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    output logic [15:0] line_cnt
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAKE    = 3'd1;
    localparam logic [2:0] S_HOME    = 3'd2;
    localparam logic [2:0] S_STEP    = 3'd3;
    localparam logic [2:0] S_SETTLE  = 3'd4;
    localparam logic [2:0] S_CAPTURE = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;
    localparam logic [2:0] S_FAULT   = 3'd7;

    localparam logic [31:0] C_HALF_LAST     = 32'(STEP_HALF - 1);
    localparam logic [31:0] C_SETTLE_LAST   = 32'(SETTLE_CYC - 1);
    localparam logic [31:0] C_LINE_TMO_LAST = 32'd65535;
    localparam logic [15:0] C_HOME_MAX      = 16'(HOME_MAX);

    // FSM and datapath state
    logic [2:0]  state_q,    state_d;
    logic [31:0] cnt_q,      cnt_d;       // phase / settle / timeout cycle counter
    logic        phase_q,    phase_d;     // 1 = step high phase
    logic [15:0] step_cnt_q, step_cnt_d;  // steps completed (counted on falling edge)
    logic [15:0] nl_q,       nl_d;
    logic [7:0]  spl_q,      spl_d;
    logic        dir_cfg_q,  dir_cfg_d;
    logic [15:0] line_cnt_q, line_cnt_d;
    logic [1:0]  err_q,      err_d;
    logic        mtr_dir_q,  mtr_dir_d;

    // Synchronisers: bit 1 is the synchronised copy
    logic [1:0]  nhome_sync_q, nhome_sync_d;
    logic [1:0]  nflt_sync_q,  nflt_sync_d;

    // Registered outputs
    logic mtr_nen_q,  mtr_nen_d;
    logic mtr_step_q, mtr_step_d;
    logic mtr_nrst_q, mtr_nrst_d;
    logic mtr_slp_q,  mtr_slp_d;
    logic ccd_trig_q, ccd_trig_d;
    logic busy_q,     busy_d;
    logic done_q,     done_d;

    logic        go_done;
    logic        in_busy;
    logic        woken_next;
    logic [15:0] line_inc;
    logic        nhome_s;
    logic        nflt_s;

    assign nhome_s = nhome_sync_q[1];
    assign nflt_s  = nflt_sync_q[1];

    // State register: all flops, synchronous active-high reset
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 32'd0;
            phase_q      <= 1'b0;
            step_cnt_q   <= 16'd0;
            nl_q         <= 16'd0;
            spl_q        <= 8'd0;
            dir_cfg_q    <= 1'b0;
            line_cnt_q   <= 16'd0;
            err_q        <= 2'd0;
            mtr_dir_q    <= 1'b0;
            nhome_sync_q <= 2'b11;
            nflt_sync_q  <= 2'b11;
            mtr_nen_q    <= 1'b1;
            mtr_step_q   <= 1'b0;
            mtr_nrst_q   <= 1'b0;
            mtr_slp_q    <= 1'b0;
            ccd_trig_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            step_cnt_q   <= step_cnt_d;
            nl_q         <= nl_d;
            spl_q        <= spl_d;
            dir_cfg_q    <= dir_cfg_d;
            line_cnt_q   <= line_cnt_d;
            err_q        <= err_d;
            mtr_dir_q    <= mtr_dir_d;
            nhome_sync_q <= nhome_sync_d;
            nflt_sync_q  <= nflt_sync_d;
            mtr_nen_q    <= mtr_nen_d;
            mtr_step_q   <= mtr_step_d;
            mtr_nrst_q   <= mtr_nrst_d;
            mtr_slp_q    <= mtr_slp_d;
            ccd_trig_q   <= ccd_trig_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Two-flop synchroniser shift for the asynchronous motor inputs
    always_comb begin
        nhome_sync_d = {nhome_sync_q[0], mtr_nhome};
        nflt_sync_d  = {nflt_sync_q[0],  mtr_nflt};
    end

    // Next-state logic: abort > driver fault > normal sequencing
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        step_cnt_d = step_cnt_q;
        nl_d       = nl_q;
        spl_d      = spl_q;
        dir_cfg_d  = dir_cfg_q;
        line_cnt_d = line_cnt_q;
        err_d      = err_q;
        mtr_dir_d  = mtr_dir_q;
        go_done    = 1'b0;
        line_inc   = (line_cnt_q == 16'hFFFF) ? line_cnt_q : line_cnt_q + 16'd1;
        in_busy    = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_FAULT);

        if (abort) begin
            state_d = S_IDLE;
        end else if (in_busy && !nflt_s) begin
            state_d = S_FAULT;
            err_d   = 2'd1;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_FAULT: begin
                    if (start) begin
                        nl_d       = num_lines;
                        spl_d      = steps_per_line;
                        dir_cfg_d  = dir_fwd;
                        err_d      = 2'd0;
                        line_cnt_d = 16'd0;
                        cnt_d      = 32'd0;
                        step_cnt_d = 16'd0;
                        phase_d    = 1'b0;
                        if (num_lines == 16'd0) begin
                            state_d = S_DONE;
                            go_done = 1'b1;
                        end else begin
                            state_d   = S_WAKE;
                            mtr_dir_d = ~dir_fwd;
                        end
                    end
                end
                S_WAKE: begin
                    if (cnt_q >= C_SETTLE_LAST) begin
                        // Enter HOME at the end of a virtual low phase so the
                        // home switch is checked before any step is issued.
                        state_d    = S_HOME;
                        cnt_d      = C_HALF_LAST;
                        phase_d    = 1'b0;
                        step_cnt_d = 16'd0;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                S_HOME, S_STEP: begin
                    if (cnt_q < C_HALF_LAST) begin
                        cnt_d = cnt_q + 32'd1;
                    end else begin
                        cnt_d = 32'd0;
                        if (phase_q) begin
                            phase_d = 1'b0;
                            if (step_cnt_q != 16'hFFFF) begin
                                step_cnt_d = step_cnt_q + 16'd1;
                            end
                        end else if (state_q == S_HOME) begin
                            if (!nhome_s) begin
                                state_d   = S_SETTLE;
                                mtr_dir_d = dir_cfg_q;
                            end else if (step_cnt_q >= C_HOME_MAX) begin
                                state_d = S_FAULT;
                                err_d   = 2'd2;
                            end else begin
                                phase_d = 1'b1;
                            end
                        end else begin
                            if (step_cnt_q >= {8'd0, spl_q}) begin
                                state_d = S_SETTLE;
                            end else begin
                                phase_d = 1'b1;
                            end
                        end
                    end
                end
                S_SETTLE: begin
                    if (cnt_q >= C_SETTLE_LAST) begin
                        state_d = S_CAPTURE;
                        cnt_d   = 32'd0;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                S_CAPTURE: begin
                    // cnt_q == 0 is the trigger cycle; line_done there is ignored
                    if (line_done && (cnt_q != 32'd0)) begin
                        line_cnt_d = line_inc;
                        cnt_d      = 32'd0;
                        if (line_inc == nl_q) begin
                            state_d = S_DONE;
                            go_done = 1'b1;
                        end else if (spl_q == 8'd0) begin
                            state_d = S_SETTLE;
                        end else begin
                            // Start with a full low phase so the first rising
                            // edge trails the last direction change.
                            state_d    = S_STEP;
                            phase_d    = 1'b0;
                            step_cnt_d = 16'd0;
                        end
                    end else if (cnt_q >= C_LINE_TMO_LAST) begin
                        state_d = S_FAULT;
                        err_d   = 2'd3;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Output decode from the next state, registered one cycle after its cause
    always_comb begin
        woken_next = (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_FAULT);
        mtr_nen_d  = ~woken_next;
        mtr_nrst_d = woken_next;
        mtr_slp_d  = woken_next;
        busy_d     = woken_next;
        mtr_step_d = ((state_d == S_HOME) || (state_d == S_STEP)) && phase_d;
        ccd_trig_d = (state_d == S_CAPTURE) && (state_q != S_CAPTURE);
        done_d     = go_done;
    end

    assign mtr_nen  = mtr_nen_q;
    assign mtr_step = mtr_step_q;
    assign mtr_dir  = mtr_dir_q;
    assign mtr_nrst = mtr_nrst_q;
    assign mtr_slp  = mtr_slp_q;
    assign ccd_trig = ccd_trig_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign line_cnt = line_cnt_q;

endmodule
`default_nettype wire
